// File: rtl/serial_deframer_pkg.sv
// Shared types and constants for the serial deframer.
package serial_deframer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

endpackage

// File: rtl/sync_fifo.sv
// Fall-through synchronous FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  // Head is forced to zero when empty so the outputs are clean out of reset.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop_i & ~empty_o;
    do_push  = push_i & (~full_o | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = AW'(wr_ptr_q + AW'(1));
    if (do_pop)  rd_ptr_d = AW'(rd_ptr_q + AW'(1));
    case ({do_push, do_pop})
      2'b10:   level_d = LW'(level_q + LW'(1));
      2'b01:   level_d = LW'(level_q - LW'(1));
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: reads are masked while empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/serial_deframer.sv
// Serial-to-parallel receiver: frames qualified bits into words, optional parity check, FIFO output.
module serial_deframer
  import serial_deframer_pkg::*;
#(
  parameter int unsigned WIDTH     = 10,
  parameter int unsigned LSB_FIRST = 1,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       sdata_i,
  input  logic                       sbit_en_i,
  input  logic                       sframe_i,
  input  logic                       clr_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       perr_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       overflow_o,
  output logic                       frame_err_o
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             par_q, par_d;
  logic             ovf_q, ovf_d;
  logic             ferr_q, ferr_d;

  logic             push, perr, ferr_set, pop, drop;
  logic             fifo_full, fifo_empty;
  logic [WIDTH:0]   fifo_rdata;

  // Shifting in from the appropriate end lands the first bit at [0] or [WIDTH-1].
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] s, input logic b);
    if (LSB_FIRST != 0) return {b, s[WIDTH-1:1]};
    else                return {s[WIDTH-2:0], b};
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    push     = 1'b0;
    perr     = 1'b0;
    ferr_set = 1'b0;
    if (sbit_en_i) begin
      if (sframe_i) begin
        // A frame marker always restarts; it is an error only if a frame was in progress.
        ferr_set = (state_q != IDLE);
        shreg_d  = shift_in(shreg_q, sdata_i);
        par_d    = sdata_i;
        cnt_d    = CW'(1);
        state_d  = SHIFT;
      end else begin
        case (state_q)
          IDLE: ;
          SHIFT: begin
            shreg_d = shift_in(shreg_q, sdata_i);
            par_d   = par_q ^ sdata_i;
            if (cnt_q == CW'(WIDTH-1)) begin
              cnt_d = '0;
              if (PARITY == PAR_NONE) begin
                push    = 1'b1;
                state_d = IDLE;
              end else begin
                state_d = PAR;
              end
            end else begin
              cnt_d = CW'(cnt_q + CW'(1));
            end
          end
          PAR: begin
            push    = 1'b1;
            perr    = (par_q ^ sdata_i) ^ (PARITY == PAR_ODD);
            state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  assign pop  = ~fifo_empty & ready_i;
  assign drop = push & fifo_full & ~pop;

  always_comb begin
    ovf_d  = (ovf_q & ~clr_i) | drop;
    ferr_d = (ferr_q & ~clr_i) | ferr_set;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      ovf_q   <= ovf_d;
      ferr_q  <= ferr_d;
    end
  end

  sync_fifo #(
    .WIDTH (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .wdata_i ({perr, shreg_d}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level_o)
  );

  assign data_o      = fifo_rdata[WIDTH-1:0];
  assign perr_o      = fifo_rdata[WIDTH];
  assign valid_o     = ~fifo_empty;
  assign overflow_o  = ovf_q;
  assign frame_err_o = ferr_q;

endmodule

// File: tb/tb_serial_deframer.sv
// Randomised scoreboard bench for serial_deframer over four parameter sets sharing one serial stream.
module tb_serial_deframer;

  logic clk, rst_n, sdata, sbit_en, sframe, clr, ready;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   rnd_ctl = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, g, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned LSB  = (g == 1 || g == 3) ? 0 : 1;
    localparam int unsigned PAR  = (g == 2) ? 1 : ((g == 3) ? 2 : 0);
    localparam int unsigned DEP  = (g == 3) ? 2 : 4;
    localparam int unsigned LW   = $clog2(DEP + 1);
    localparam int          FLEN = (PAR != 0) ? 11 : 10;

    logic [9:0]    data;
    logic          perr, valid, ovf, ferr;
    logic [LW-1:0] level;

    serial_deframer #(.WIDTH(10), .LSB_FIRST(LSB), .PARITY(PAR), .DEPTH(DEP)) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .sdata_i(sdata), .sbit_en_i(sbit_en), .sframe_i(sframe),
      .clr_i(clr), .data_o(data), .perr_o(perr), .valid_o(valid), .ready_i(ready),
      .level_o(level), .overflow_o(ovf), .frame_err_o(ferr)
    );

    // Reference: collect the bits of a frame, assemble the word when complete, keep FIFO contents as a queue.
    logic [10:0] fifo_m [$];
    bit          bits_m [$];
    bit          active_m = 0;
    bit          ovf_m = 0;
    bit          ferr_m = 0;

    always @(posedge clk or negedge rst_n) begin : p_model
      bit         pop_m, push_m, fset;
      logic [9:0] w;
      logic       pe;
      if (!rst_n) begin
        fifo_m.delete();
        bits_m.delete();
        active_m = 0;
        ovf_m    = 0;
        ferr_m   = 0;
      end else begin
        pop_m  = ready && (fifo_m.size() > 0);
        push_m = 0;
        fset   = 0;
        w      = '0;
        pe     = 1'b0;
        if (sbit_en) begin
          if (sframe) begin
            fset = active_m;
            bits_m.delete();
            bits_m.push_back(sdata);
            active_m = 1;
          end else if (active_m) begin
            bits_m.push_back(sdata);
          end
          if (active_m && bits_m.size() == FLEN) begin
            for (int i = 0; i < 10; i++) begin
              if (LSB != 0) w[i] = bits_m[i];
              else          w[9-i] = bits_m[i];
            end
            if (PAR == 1) pe = ((^w) ^ bits_m[10]) != 1'b0;
            if (PAR == 2) pe = ((^w) ^ bits_m[10]) != 1'b1;
            push_m   = 1;
            active_m = 0;
            bits_m.delete();
          end
        end
        if (clr) begin
          ovf_m  = 0;
          ferr_m = 0;
        end
        if (fset) ferr_m = 1;
        if (push_m && fifo_m.size() == DEP && !pop_m) begin
          ovf_m = 1;
        end else begin
          if (pop_m)  void'(fifo_m.pop_front());
          if (push_m) fifo_m.push_back({pe, w});
        end
      end
    end

    // Monitor: compare presented outputs against the reference every cycle.
    always @(negedge clk) begin
      chk("valid", g, 32'(valid), 32'(fifo_m.size() > 0));
      chk("level", g, 32'(level), 32'(fifo_m.size()));
      chk("overflow", g, 32'(ovf), 32'(ovf_m));
      chk("frame_err", g, 32'(ferr), 32'(ferr_m));
      if (fifo_m.size() > 0) begin
        chk("data", g, 32'(data), 32'(fifo_m[0][9:0]));
        chk("perr", g, 32'(perr), 32'(fifo_m[0][10]));
      end
    end
  end

  task automatic send_bit(input logic b, input logic f, input int gap);
    sdata   = b;
    sframe  = f;
    sbit_en = 1'b1;
    if (rnd_ctl) begin
      ready = ($urandom_range(0, 3) != 0);
      clr   = ($urandom_range(0, 15) == 0);
    end
    @(negedge clk);
    sbit_en = 1'b0;
    sframe  = 1'b0;
    clr     = 1'b0;
    sdata   = 1'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [9:0] w, input int nbits, input bit with_par,
                           input logic pbit, input int maxgap);
    for (int i = 0; i < nbits; i++)
      send_bit(w[i], i == 0, (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
    if (with_par) send_bit(pbit, 1'b0, (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 0, 32'(g_dut[0].valid), 0);
    chk("rst_level", 0, 32'(g_dut[0].level), 0);
    chk("rst_data", 0, 32'(g_dut[0].data), 0);
    chk("rst_ovf", 0, 32'(g_dut[0].ovf), 0);
    chk("rst_ferr", 0, 32'(g_dut[0].ferr), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin : p_main
    logic [9:0] w [5];
    logic [9:0] a;
    clk = 0; rst_n = 0; sdata = 0; sbit_en = 0; sframe = 0; clr = 0; ready = 1;

    // Basic word, LSB-first and MSB-first views of the same stream.
    do_reset();
    ready = 0;
    send_word(10'h31B, 10, 0, 1'b0, 0);
    chk("t1_valid", 0, 32'(g_dut[0].valid), 1);
    chk("t1_data", 0, 32'(g_dut[0].data), 32'h31B);
    chk("t1_perr", 0, 32'(g_dut[0].perr), 0);
    chk("t2_data_msb", 1, 32'(g_dut[1].data), 32'h363);

    // Even parity: bad then good parity bit.
    do_reset();
    ready = 0;
    send_word(10'h31B, 10, 1, 1'b1, 0);
    chk("t3_data", 2, 32'(g_dut[2].data), 32'h31B);
    chk("t3_perr1", 2, 32'(g_dut[2].perr), 1);
    send_word(10'h31B, 10, 1, 1'b0, 0);
    ready = 1;
    @(negedge clk);
    ready = 0;
    chk("t3_perr0", 2, 32'(g_dut[2].perr), 0);

    // Overflow with five frames into four entries, then ordered drain and clear.
    do_reset();
    ready = 0;
    for (int k = 0; k < 5; k++) begin
      w[k] = 10'($urandom);
      send_word(w[k], 10, 0, 1'b0, 0);
    end
    chk("t4_level", 0, 32'(g_dut[0].level), 4);
    chk("t4_ovf", 0, 32'(g_dut[0].ovf), 1);
    ready = 1;
    for (int k = 0; k < 4; k++) begin
      chk("t4_drain", 0, 32'(g_dut[0].data), 32'(w[k]));
      @(negedge clk);
    end
    chk("t4_empty", 0, 32'(g_dut[0].valid), 0);
    clr = 1;
    @(negedge clk);
    clr = 0;
    chk("t4_clr", 0, 32'(g_dut[0].ovf), 0);

    // Mid-frame marker restarts the frame.
    do_reset();
    ready = 1;
    a = 10'($urandom);
    w[0] = 10'($urandom);
    send_word(a, 5, 0, 1'b0, 0);
    send_word(w[0], 10, 0, 1'b0, 0);
    chk("t5_ferr", 0, 32'(g_dut[0].ferr), 1);
    chk("t5_data", 0, 32'(g_dut[0].data), 32'(w[0]));
    for (int k = 0; k < 20; k++) send_word(10'($urandom), 10, 1, 1'($urandom), 7);
    repeat (4) @(negedge clk);

    // Reset mid-frame with queued words.
    do_reset();
    ready = 0;
    send_word(10'($urandom), 10, 0, 1'b0, 0);
    send_word(10'($urandom), 10, 0, 1'b0, 0);
    send_word(10'($urandom), 4, 0, 1'b0, 0);
    chk("t6_pre_level", 0, 32'(g_dut[0].level), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", 0, 32'(g_dut[0].valid), 0);
    chk("t6_level", 0, 32'(g_dut[0].level), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    a = 10'($urandom);
    send_word(a, 10, 0, 1'b0, 0);
    chk("t6_data", 0, 32'(g_dut[0].data), 32'(a));
    chk("t6_valid2", 0, 32'(g_dut[0].valid), 1);

    // Random traffic: gaps, back-pressure, clears, truncated frames, optional parity bit.
    rnd_ctl = 1;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 9) == 0)
        send_word(10'($urandom), $urandom_range(1, 9), 0, 1'b0, 3);
      else
        send_word(10'($urandom), 10, 1'($urandom), 1'($urandom), $urandom_range(0, 7));
    end
    rnd_ctl = 0;
    ready = 1;
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
